// File: rtl/alu_pkg.sv
// ALU-wide constants: operator codes, datapath width and the mul/div FSM states.
package alu_pkg;

    localparam int XLEN = 32;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_SLT = 4'd2;
    localparam logic [3:0] OP_MUL = 4'd3;
    localparam logic [3:0] OP_DIV = 4'd4;
    localparam logic [3:0] OP_AND = 4'd5;
    localparam logic [3:0] OP_OR  = 4'd6;
    localparam logic [3:0] OP_XOR = 4'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_SIGN = 2'd2
    } md_state_t;

endpackage

// File: rtl/signed_abs.sv
// Conditional two's-complement negate: magnitude of a signed value when
// i_neg is its sign bit, or sign restoration of a magnitude.
module signed_abs #(
    parameter int W = 33
) (
    input  logic [W-1:0] i_val,
    input  logic         i_neg,
    output logic [W-1:0] o_val
);

    assign o_val = i_neg ? (~i_val + {{(W-1){1'b0}}, 1'b1}) : i_val;

endmodule

// File: rtl/muldiv_unit.sv
// Radix-2 iterative signed multiply/divide with start/busy/done handshake.
// Fixed WIDTH+1 cycle latency; operands are reduced to magnitudes and re-signed at the end.
module muldiv_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = XLEN
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       operator,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result2,
    output logic             div_zero
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    md_state_t        r_state;
    md_state_t        w_state_nxt;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH:0]   r_a;
    logic [WIDTH:0]   r_b;
    logic [WIDTH:0]   r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_neg_x;
    logic             r_neg_y;
    logic             r_is_div;
    logic             r_dz;
    logic             r_done;
    logic [WIDTH-1:0] r_result;
    logic [WIDTH-1:0] r_result2;
    logic             r_div_zero;

    logic             w_accept;
    logic [WIDTH:0]   w_abs_x;
    logic [WIDTH:0]   w_abs_y;
    logic [WIDTH:0]   w_mul_sum;
    logic [WIDTH:0]   w_rem_sh;
    logic             w_rem_ge;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0] w_quot_fix;
    logic [WIDTH-1:0] w_rem_fix;

    assign w_accept = start && (operator == OP_MUL || operator == OP_DIV);

    // Sign-extended to WIDTH+1 so that |-2^(WIDTH-1)| is representable.
    signed_abs #(.W(WIDTH + 1)) u_abs_x (
        .i_val ({x[WIDTH-1], x}),
        .i_neg (x[WIDTH-1]),
        .o_val (w_abs_x)
    );

    signed_abs #(.W(WIDTH + 1)) u_abs_y (
        .i_val ({y[WIDTH-1], y}),
        .i_neg (y[WIDTH-1]),
        .o_val (w_abs_y)
    );

    signed_abs #(.W(2 * WIDTH)) u_fix_prod (
        .i_val ({r_hi[WIDTH-1:0], r_lo}),
        .i_neg (r_neg_x ^ r_neg_y),
        .o_val (w_prod_fix)
    );

    signed_abs #(.W(WIDTH)) u_fix_quot (
        .i_val (r_lo),
        .i_neg (r_neg_x ^ r_neg_y),
        .o_val (w_quot_fix)
    );

    signed_abs #(.W(WIDTH)) u_fix_rem (
        .i_val (r_hi[WIDTH-1:0]),
        .i_neg (r_neg_x),
        .o_val (w_rem_fix)
    );

    assign w_mul_sum = r_hi + (r_lo[0] ? r_a : '0);
    assign w_rem_sh  = {r_hi[WIDTH-1:0], r_lo[WIDTH-1]};
    assign w_rem_ge  = (w_rem_sh >= r_b);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_state_nxt = ST_CALC;
            ST_CALC: if (r_cnt == LAST) w_state_nxt = ST_SIGN;
            ST_SIGN: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt      <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_neg_x    <= 1'b0;
            r_neg_y    <= 1'b0;
            r_is_div   <= 1'b0;
            r_dz       <= 1'b0;
            r_done     <= 1'b0;
            r_result   <= '0;
            r_result2  <= '0;
            r_div_zero <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_a        <= w_abs_x;
                        r_b        <= w_abs_y;
                        r_neg_x    <= x[WIDTH-1];
                        r_neg_y    <= y[WIDTH-1];
                        r_is_div   <= (operator == OP_DIV);
                        r_dz       <= (operator == OP_DIV) && (y == '0);
                        r_hi       <= '0;
                        r_lo       <= (operator == OP_DIV) ? w_abs_x[WIDTH-1:0] : w_abs_y[WIDTH-1:0];
                        r_cnt      <= '0;
                        r_div_zero <= 1'b0;
                    end
                end
                ST_CALC: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_is_div) begin
                        r_hi <= w_rem_ge ? (w_rem_sh - r_b) : w_rem_sh;
                        r_lo <= {r_lo[WIDTH-2:0], w_rem_ge};
                    end else begin
                        // r_lo doubles as multiplier shift register and product low word.
                        r_hi <= {1'b0, w_mul_sum[WIDTH:1]};
                        r_lo <= {w_mul_sum[0], r_lo[WIDTH-1:1]};
                    end
                end
                ST_SIGN: begin
                    r_done <= 1'b1;
                    if (r_is_div) begin
                        r_result   <= r_dz ? '1 : w_quot_fix;
                        r_result2  <= w_rem_fix;
                        r_div_zero <= r_dz;
                    end else begin
                        r_result   <= w_prod_fix[WIDTH-1:0];
                        r_result2  <= w_prod_fix[2*WIDTH-1:WIDTH];
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy     = (r_state != ST_IDLE);
    assign done     = r_done;
    assign result   = r_result;
    assign result2  = r_result2;
    assign div_zero = r_div_zero;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit using immediate assertions.
module tb_muldiv_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [3:0]  operator;
    logic [31:0] x;
    logic [31:0] y;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [31:0] result2;
    logic        div_zero;

    int checks = 0;
    int errors = 0;
    int edges;
    int ndone;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .operator (operator),
        .x        (x),
        .y        (y),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .result2  (result2),
        .div_zero (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive a request for one edge; returns #1 after the accepting edge.
    task automatic launch(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        operator = op;
        x        = a;
        y        = b;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = -1;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic count_done(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            if (done) n++;
        end
    endtask

    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_lo,
                          input logic [31:0] exp_hi, input logic exp_dz);
        int n;
        launch(op, a, b);
        check({tag, " busy"}, 64'(busy), 64'(1));
        wait_done(n);
        check({tag, " latency"}, 64'(n), 64'(33));
        check({tag, " result"}, 64'(result), 64'(exp_lo));
        check({tag, " result2"}, 64'(result2), 64'(exp_hi));
        check({tag, " div_zero"}, 64'(div_zero), 64'(exp_dz));
        check({tag, " busy_at_done"}, 64'(busy), 64'(0));
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        operator = 4'd0;
        x        = '0;
        y        = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", 64'(busy), 64'(0));
        check("reset done", 64'(done), 64'(0));
        check("reset result", 64'(result), 64'(0));
        check("reset result2", 64'(result2), 64'(0));
        check("reset div_zero", 64'(div_zero), 64'(0));
        rst = 1'b0;

        run_op("mul_65537", 4'd3, 32'd65537, 32'd65537, 32'h0002_0001, 32'h0000_0001, 1'b0);
        run_op("mul_m3x4", 4'd3, -32'sd3, 32'd4, 32'hFFFF_FFF4, 32'hFFFF_FFFF, 1'b0);
        run_op("mul_m3xm4", 4'd3, -32'sd3, -32'sd4, 32'd12, 32'd0, 1'b0);
        run_op("mul_minsq", 4'd3, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 32'h4000_0000, 1'b0);
        run_op("div_19_7", 4'd4, 32'd19, 32'd7, 32'd2, 32'd5, 1'b0);
        run_op("div_m19_7", 4'd4, -32'sd19, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFB, 1'b0);
        run_op("div_zero", 4'd4, 32'd10, 32'd0, 32'hFFFF_FFFF, 32'd10, 1'b1);
        run_op("div_16_4", 4'd4, 32'd16, 32'd4, 32'd4, 32'd0, 1'b0);
        run_op("div_ovf", 4'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0);
        run_op("div_zero_neg", 4'd4, -32'sd7, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b1);

        // Start while busy is ignored; operand changes after acceptance have no effect.
        launch(4'd3, 32'd2, 32'd3);
        repeat (4) @(posedge clk);
        #1;
        launch(4'd4, 32'd16, 32'd4);
        check("ign busy", 64'(busy), 64'(1));
        wait_done(edges);
        check("ign latency", 64'(edges), 64'(28));
        check("ign result", 64'(result), 64'(6));
        check("ign result2", 64'(result2), 64'(0));
        count_done(40, ndone);
        check("ign no_second_done", 64'(ndone), 64'(0));

        launch(4'd5, 32'd9, 32'd9);
        check("badop busy", 64'(busy), 64'(0));
        count_done(5, ndone);
        check("badop no_done", 64'(ndone), 64'(0));
        check("badop result_held", 64'(result), 64'(6));

        // Reset mid-operation aborts it.
        launch(4'd4, 32'd100, 32'd7);
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst busy", 64'(busy), 64'(0));
        check("rst result", 64'(result), 64'(0));
        check("rst result2", 64'(result2), 64'(0));
        check("rst done", 64'(done), 64'(0));
        count_done(40, ndone);
        check("rst no_done", 64'(ndone), 64'(0));

        // Reset and start in the same cycle: reset wins.
        rst = 1'b1;
        launch(4'd3, 32'd5, 32'd5);
        rst = 1'b0;
        check("rst_start busy", 64'(busy), 64'(0));
        count_done(40, ndone);
        check("rst_start no_done", 64'(ndone), 64'(0));

        run_op("mul_after_rst", 4'd3, 32'd2, 32'd3, 32'd6, 32'd0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

- Sequential signed multiply/divide unit; the operation side of the CPU ALU operand interface.
- Accepts the same operand pair `x`/`y`, the same 4-bit `operator` encoding (3 = multiply, 4 = divide) and the same two-word result convention (`result` = low word/quotient, `result2` = high word/remainder).
- Replaces single-cycle combinational mul/div with a radix-2 iterative datapath, using a start/busy/done handshake.
- Sits beside the combinational ALU in EX; the pipeline stalls while `busy` is high.

## Interface
- `WIDTH`, 32: operand width. Iteration count equals `WIDTH`.
- `clk`  input  1  sole clock; all state updates on rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `start`  input  1  request strobe, sampled only when `busy`=0.
- `operator`  input  4  ALU op code; only 3 (MUL) and 4 (DIV) are accepted.
- `x`  input  WIDTH  multiplicand / dividend, two's complement.
- `y`  input  WIDTH  multiplier / divisor, two's complement.
- `busy`  output  1  high from the cycle after acceptance until `done`.
- `done`  output  1  one-cycle pulse; results are valid from this cycle on.
- `result`  output  WIDTH  MUL: product[WIDTH-1:0]; DIV: quotient.
- `result2`  output  WIDTH  MUL: product[2*WIDTH-1:WIDTH]; DIV: remainder.
- `div_zero`  output  1  set with `done` when DIV had `y`=0; held until the next acceptance.

## Operation
- FSM states: IDLE, CALC, SIGN.
- IDLE, `start`=1, `operator`∈{3,4}:
  - latch |x|, |y|, the sign flags and the op;
  - clear the accumulator and the counter;
  - go to CALC.
- `start` with any other op, or while `busy`=1: ignored. No state change, no `done`.
- CALC, MUL: shift-add on magnitudes. Each cycle, if the multiplier LSB is 1, add the multiplicand to the upper half of the 2·WIDTH accumulator, then shift right.
- CALC, DIV: restoring division. Each cycle, shift {rem, quot} left; if rem ≥ |y|, subtract and set the quotient LSB.
- The counter runs 0..WIDTH-1. At WIDTH-1, go to SIGN.
- SIGN:
  - MUL: negate the 64-bit product if sign(x)≠sign(y).
  - DIV: negate the quotient if the signs differ; negate the remainder if x<0. Quotient truncates toward zero; the remainder takes the dividend's sign.
  - Register `result`/`result2`, pulse `done`, return to IDLE.
- Divide by zero: runs the full latency. `result`=all-ones, `result2`=x, `div_zero`=1.
- −2^WIDTH-1 ÷ −1: `result`=0x80000000, `result2`=0. No flag.
- Magnitude math is WIDTH+1 bits internally so that |−2^31| is exact.
- Outputs hold their last values until the next `done`. A new acceptance does not clear `result`/`result2`.

## Timing
- Reset values: `busy`=0, `done`=0, `div_zero`=0, `result`=0, `result2`=0, state IDLE, counter 0.
- Start accepted at edge E0 → `busy`=1 after E0.
- CALC occupies edges E1..E32. SIGN completes at E33, giving `done`=1 and `busy`=0 in the cycle after E33.
- Fixed latency: WIDTH+1 edges from acceptance to `done` (33 for WIDTH=32). Does not depend on the data.
- The earliest next acceptance is the edge ending the `done` cycle; back-to-back operations are allowed.
- `rst` mid-operation: abort at that edge and apply reset values. No `done` is produced for the aborted op.
- `rst` and `start` in the same cycle: `rst` wins and `start` is dropped.
- `x`/`y`/`operator` are sampled only at acceptance; later changes have no effect.

## Structure
- Shared package `alu_pkg`:
  - `OP_MUL`=4'd3, `OP_DIV`=4'd4, alongside the existing ALU op constants;
  - FSM state encoding (IDLE/CALC/SIGN);
  - `XLEN`=32.
- One sub-module is natural: `signed_abs`, a combinational magnitude/negate helper used for both operands and the final sign fix.
- The datapath and FSM stay in `muldiv_unit`.

## Test plan
- MUL x=65537, y=65537 → `done` exactly 33 edges after acceptance, `result`=0x00020001, `result2`=0x00000001.
- MUL x=−3, y=4 → `result`=0xFFFFFFF4, `result2`=0xFFFFFFFF. Then x=−3, y=−4 → `result`=12, `result2`=0.
- DIV x=19, y=7 → `result`=2, `result2`=5. Then x=−19, y=7 → `result`=0xFFFFFFFE, `result2`=0xFFFFFFFB.
- DIV x=10, y=0 → `result`=0xFFFFFFFF, `result2`=10, `div_zero`=1. Then DIV x=16, y=4 → `div_zero`=0, `result`=4, `result2`=0.
- MUL 2×3 accepted, then `start` with DIV 16/4 at cycle 5 → ignored. A single `done` arrives with `result`=6; `operator`=5 with `start` in IDLE → `busy` stays 0.
- Start DIV, assert `rst` at cycle 10 → all outputs 0 next cycle and no `done`. Then MUL 2×3 → `result`=6 after 33 edges.
